arb_mux_nxw: RTL and testbench
==============================

ARB_MUX_NXW -- requirements
Module: arb_mux_nxw

Interface
REQ-001 Parameter WIDTH, default 5, data bits per channel.
REQ-002 Parameter NCH, default 4, number of input channels (2..16).
REQ-003 Parameter MODE, default 1, arbitration mode: 0 = fixed priority (channel 0 highest), 1 = round-robin.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 in_valid  input  NCH  per-channel request.
REQ-007 in_data  input  NCH*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH].
REQ-008 in_ready  output  NCH  one-hot grant/accept; bit k high means channel k transfers this cycle.
REQ-009 out_valid  output  1  output register holds a word.
REQ-010 out_data  output  WIDTH  registered selected word.
REQ-011 out_sel  output  clog2(NCH)  index of channel that supplied out_data.
REQ-012 out_ready  input  1  downstream accepts out_data when out_valid high.

Function
REQ-013 Input transfer on channel k occurs when in_valid[k] and in_ready[k] are both high at a rising edge.
REQ-014 Output transfer occurs when out_valid and out_ready are both high at a rising edge.
REQ-015 Output register is loadable when out_valid low or an output transfer occurs that cycle.
REQ-016 in_ready is all-zero when the output register is not loadable; otherwise it is one-hot on the winner among asserted in_valid, or all-zero if none.
REQ-017 in_ready depends combinationally on in_valid, out_ready and state; it never depends on in_data.
REQ-018 MODE 0 winner: lowest-index asserted channel.
REQ-019 MODE 1 winner: first asserted channel scanning upward from pointer ptr, wrapping NCH-1 to 0.
REQ-020 After each input transfer from channel k, ptr becomes (k+1) mod NCH; otherwise ptr holds.
REQ-021 Latency: a word accepted at edge n appears on out_data/out_sel with out_valid high after edge n; throughput one word per cycle with out_ready held high.
REQ-022 Simultaneous output transfer and input transfer in one cycle replaces the register contents with no bubble and no loss.
REQ-023 With out_valid high and out_ready low, out_data, out_sel and out_valid hold stable.
REQ-024 Controller states: EMPTY (out_valid=0), FULL (out_valid=1), plus LOCKED when REQ-031 is compiled in; EMPTY->FULL on input transfer, FULL->EMPTY on output transfer with no input transfer, FULL->FULL otherwise.
REQ-025 A requester dropping in_valid without a transfer causes no state change.

Reset
REQ-026 rst_n low asynchronously forces out_valid=0, out_data=0, out_sel=0, ptr=0, state EMPTY, lock cleared.
REQ-027 in_ready is all-zero while rst_n is low.
REQ-028 A word held at reset assertion is discarded; first grant after release follows ptr=0.

Configuration
REQ-029 Macro ARB_MUX_NXW_LOCK_EN compiles in an input in_lock, width NCH.
REQ-030 Without the macro: no in_lock port; behaviour per REQ-013..REQ-025 only.
REQ-031 With the macro: a transfer on channel k with in_lock[k] high enters LOCKED on k; while LOCKED, only channel k may win, ptr holds; a transfer from k with in_lock[k] low returns to normal arbitration with ptr=(k+1) mod NCH.
REQ-032 With the macro, reset clears LOCKED regardless of in_lock.

Structure
REQ-033 Shared package arb_mux_pkg holds MODE constants (ARB_FIXED=0, ARB_RR=1) and the clog2-based index width function.
REQ-034 One sub-module rr_pick: combinational NCH-wide request vector plus start index in, one-hot grant plus index out; reused for both modes with start fixed to 0 for MODE 0.

Verification
REQ-035 WIDTH=5, NCH=4, MODE=1, out_ready=1, in_valid=4'b1111 for 8 cycles -> out_sel sequence 0,1,2,3,0,1,2,3, one word per cycle.
REQ-036 MODE=0, in_valid=4'b1010 constant, out_ready=1 -> out_sel always 1; channel 3 never granted.
REQ-037 Channel 2 sends 5'h1F, out_ready=0 for 3 cycles -> out_data=5'h1F, out_sel=2 stable; in_ready=0 throughout; accepted on first out_ready=1 cycle.
REQ-038 Back-to-back with out_ready=1 and in_valid=4'b0001 -> word replaced each cycle, no bubble, out_valid stays 1.
REQ-039 rst_n pulsed low mid-stream while FULL -> out_valid=0, out_data=0 immediately (asynchronously); next grant with in_valid=4'b1111 is channel 0.
REQ-040 With ARB_MUX_NXW_LOCK_EN, channel 1 transfers with in_lock=4'b0010 for 3 words, in_valid=4'b1111 -> out_sel 1,1,1, then 2 after in_lock[1] drops on its last transfer.

Source files
------------

// File: rtl/arb_mux_pkg.sv
// rtl/arb_mux_pkg.sv - shared arbitration mode constants, controller states and index-width helper
package arb_mux_pkg;

    localparam int ARB_FIXED = 0;
    localparam int ARB_RR    = 1;

    typedef enum logic [1:0] {
        ST_EMPTY  = 2'd0,
        ST_FULL   = 2'd1,
        ST_LOCKED = 2'd2
    } ctl_state_e;

    function automatic int idx_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/arb_mux_nxw_if.sv
// rtl/arb_mux_nxw_if.sv - request/grant and output handshake bundle for arb_mux_nxw
interface arb_mux_nxw_if
    import arb_mux_pkg::*;
#(
    parameter int WIDTH = 5,
    parameter int NCH   = 4
);
    localparam int IW = idx_w(NCH);

    logic [NCH-1:0]       in_valid;
    logic [NCH*WIDTH-1:0] in_data;
    logic [NCH-1:0]       in_ready;
    logic                 out_valid;
    logic [WIDTH-1:0]     out_data;
    logic [IW-1:0]        out_sel;
    logic                 out_ready;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_sel
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_sel
    );

endinterface

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - first asserted request scanning upward from a start index, wrapping
module rr_pick #(
    parameter int NCH = 4,
    parameter int IW  = 2
) (
    input  logic [NCH-1:0] req,
    input  logic [IW-1:0]  start,
    output logic [NCH-1:0] gnt,
    output logic [IW-1:0]  idx
);

    always_comb begin
        int  c;
        logic found;
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        c     = 0;
        for (int i = 0; i < NCH; i++) begin
            c = (int'(start) + i) % NCH;
            if (!found && req[c]) begin
                found  = 1'b1;
                gnt[c] = 1'b1;
                idx    = IW'(c);
            end
        end
    end

endmodule

// File: rtl/arb_mux_nxw.sv
// rtl/arb_mux_nxw.sv - N-channel arbiter into a one-word output register; ARB_MUX_NXW_LOCK_EN adds in_lock
module arb_mux_nxw
    import arb_mux_pkg::*;
#(
    parameter int WIDTH = 5,
    parameter int NCH   = 4,
    parameter int MODE  = ARB_RR
) (
    input  logic           clk,
    input  logic           rst_n,
`ifdef ARB_MUX_NXW_LOCK_EN
    input  logic [NCH-1:0] in_lock,
`endif
    arb_mux_nxw_if.slave   bus
);

    localparam int IW = idx_w(NCH);

    ctl_state_e       state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [IW-1:0]    sel_q, sel_d;
    logic [IW-1:0]    ptr_q, ptr_d;

    logic [NCH-1:0] req, gnt;
    logic [IW-1:0]  start, pick_idx;
    logic           out_valid, loadable, in_xfer, out_xfer;
    logic           locked, lock_hit;
    logic [IW-1:0]  lock_ch;

`ifdef ARB_MUX_NXW_LOCK_EN
    logic          lock_q, lock_d;
    logic [IW-1:0] lock_ch_q, lock_ch_d;

    assign locked   = lock_q;
    assign lock_ch  = lock_ch_q;
    assign lock_hit = in_lock[pick_idx];

    // The lock lives apart from the register state so that draining the word keeps the channel locked.
    always_comb begin
        lock_d    = lock_q;
        lock_ch_d = lock_ch_q;
        if (in_xfer) begin
            lock_d    = lock_hit;
            lock_ch_d = pick_idx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_q    <= 1'b0;
            lock_ch_q <= '0;
        end else begin
            lock_q    <= lock_d;
            lock_ch_q <= lock_ch_d;
        end
    end
`else
    assign locked   = 1'b0;
    assign lock_ch  = '0;
    assign lock_hit = 1'b0;
`endif

    assign req   = locked ? (bus.in_valid & (NCH'(1) << lock_ch)) : bus.in_valid;
    assign start = (MODE == ARB_FIXED) ? '0 : ptr_q;

    rr_pick #(.NCH(NCH), .IW(IW)) u_pick (
        .req   (req),
        .start (start),
        .gnt   (gnt),
        .idx   (pick_idx)
    );

    assign out_valid = (state_q != ST_EMPTY);
    assign out_xfer  = out_valid && bus.out_ready;
    assign loadable  = !out_valid || bus.out_ready;
    assign in_xfer   = |bus.in_ready;

    // Grants are suppressed while reset is held so nothing is accepted into a cleared register.
    assign bus.in_ready  = (rst_n && loadable) ? gnt : '0;
    assign bus.out_valid = out_valid;
    assign bus.out_data  = data_q;
    assign bus.out_sel   = sel_q;

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        sel_d   = sel_q;
        ptr_d   = ptr_q;
        if (in_xfer) begin
            data_d  = bus.in_data[int'(pick_idx)*WIDTH +: WIDTH];
            sel_d   = pick_idx;
            state_d = lock_hit ? ST_LOCKED : ST_FULL;
            if (!(locked && lock_hit)) begin
                ptr_d = (pick_idx == IW'(NCH - 1)) ? '0 : pick_idx + IW'(1);
            end
        end else if (out_xfer) begin
            state_d = ST_EMPTY;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_EMPTY;
            data_q  <= '0;
            sel_q   <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
        end
    end

endmodule

// File: tb/tb_arb_mux_nxw.sv
// tb/tb_arb_mux_nxw.sv - random and directed checks of round-robin and fixed-priority arb_mux_nxw
module tb_arb_mux_nxw;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  in_valid;
    logic [19:0] in_data;
    logic [3:0]  in_lock;
    logic        out_ready;

    int n_vec = 0;
    int n_err = 0;

    // Reference state per instance: index 0 is round-robin, index 1 is fixed priority.
    bit       m_full [2];
    bit [4:0] m_data [2];
    int       m_sel  [2];
    int       m_ptr  [2];
    bit       m_lock [2];
    int       m_lch  [2];

    always #5 clk = ~clk;

    arb_mux_nxw_if #(.WIDTH(5), .NCH(4)) bus_rr ();
    arb_mux_nxw_if #(.WIDTH(5), .NCH(4)) bus_fx ();

    assign bus_rr.in_valid  = in_valid;
    assign bus_rr.in_data   = in_data;
    assign bus_rr.out_ready = out_ready;
    assign bus_fx.in_valid  = in_valid;
    assign bus_fx.in_data   = in_data;
    assign bus_fx.out_ready = out_ready;

    arb_mux_nxw #(.WIDTH(5), .NCH(4), .MODE(1)) dut_rr (
        .clk     (clk),
        .rst_n   (rst_n),
`ifdef ARB_MUX_NXW_LOCK_EN
        .in_lock (in_lock),
`endif
        .bus     (bus_rr)
    );

    arb_mux_nxw #(.WIDTH(5), .NCH(4), .MODE(0)) dut_fx (
        .clk     (clk),
        .rst_n   (rst_n),
`ifdef ARB_MUX_NXW_LOCK_EN
        .in_lock (in_lock),
`endif
        .bus     (bus_fx)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int first_from(input logic [3:0] v, input int start);
        for (int i = 0; i < 4; i++) begin
            if (v[(start + i) % 4]) return (start + i) % 4;
        end
        return -1;
    endfunction

    function automatic bit lock_bit(input int ch);
`ifdef ARB_MUX_NXW_LOCK_EN
        return in_lock[ch];
`else
        return 1'b0;
`endif
    endfunction

    function automatic int winner(input int d);
        logic [3:0] v;
        if (!rst_n || (m_full[d] && !out_ready)) return -1;
        v = m_lock[d] ? (in_valid & (4'b0001 << m_lch[d])) : in_valid;
        return first_from(v, (d == 0) ? m_ptr[d] : 0);
    endfunction

    task automatic compare_all();
        int w;
        logic [3:0] exp_rdy;
        for (int d = 0; d < 2; d++) begin
            w = winner(d);
            exp_rdy = (w < 0) ? 4'b0000 : (4'b0001 << w);
            if (d == 0) begin
                check("rr_in_ready",  bus_rr.in_ready,  exp_rdy);
                check("rr_out_valid", bus_rr.out_valid, m_full[0]);
                check("rr_out_data",  bus_rr.out_data,  m_data[0]);
                check("rr_out_sel",   bus_rr.out_sel,   m_sel[0]);
            end else begin
                check("fx_in_ready",  bus_fx.in_ready,  exp_rdy);
                check("fx_out_valid", bus_fx.out_valid, m_full[1]);
                check("fx_out_data",  bus_fx.out_data,  m_data[1]);
                check("fx_out_sel",   bus_fx.out_sel,   m_sel[1]);
            end
        end
    endtask

    task automatic model_clear();
        for (int d = 0; d < 2; d++) begin
            m_full[d] = 0; m_data[d] = '0; m_sel[d] = 0;
            m_ptr[d]  = 0; m_lock[d] = 0;  m_lch[d] = 0;
        end
    endtask

    task automatic model_edge();
        int w;
        for (int d = 0; d < 2; d++) begin
            w = winner(d);
            if (w >= 0) begin
                if (!(m_lock[d] && lock_bit(w))) m_ptr[d] = (w + 1) % 4;
                m_data[d] = in_data[w*5 +: 5];
                m_sel[d]  = w;
                m_full[d] = 1;
                m_lock[d] = lock_bit(w);
                m_lch[d]  = w;
            end else if (m_full[d] && out_ready) begin
                m_full[d] = 0;
            end
        end
    endtask

    task automatic step();
        @(negedge clk);
        compare_all();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    // Reset is asserted mid-cycle so the clearing must come from the asynchronous path.
    task automatic pulse_reset();
        rst_n = 1'b0;
        #2;
        model_clear();
        compare_all();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 4'b1111; in_data = 20'h0; in_lock = 4'b0; out_ready = 1'b1;
        #1;
        pulse_reset();

        for (int i = 0; i < 8; i++) begin
            in_data = 20'($urandom);
            step();
            check("rr_seq_sel", bus_rr.out_sel, 32'(i % 4));
        end

        in_valid = 4'b1010;
        for (int i = 0; i < 6; i++) begin
            in_data = 20'($urandom);
            step();
            check("fx_1010_sel", bus_fx.out_sel, 32'd1);
        end

        in_valid = 4'b0100; in_data = 20'h07C00;
        step();
        in_valid = 4'b1111; out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_data = 20'($urandom);
            step();
            check("hold_data", bus_rr.out_data, 32'h1F);
            check("hold_sel",  bus_rr.out_sel,  32'd2);
        end
        out_ready = 1'b1;
        step();

        in_valid = 4'b0001;
        for (int i = 0; i < 5; i++) begin
            in_data = 20'($urandom);
            step();
            check("b2b_valid", bus_rr.out_valid, 1'b1);
        end

        out_ready = 1'b0; in_valid = 4'b0110;
        step();
        pulse_reset();
        in_valid = 4'b1111; out_ready = 1'b1; in_data = 20'($urandom);
        step();
        check("post_rst_sel", bus_rr.out_sel, 32'd0);

`ifdef ARB_MUX_NXW_LOCK_EN
        pulse_reset();
        in_valid = 4'b0010; in_lock = 4'b0010;
        step();
        in_valid = 4'b1111;
        step();
        check("lock_sel_2", bus_rr.out_sel, 32'd1);
        in_lock = 4'b0000;
        step();
        check("lock_sel_3", bus_rr.out_sel, 32'd1);
        step();
        check("unlock_sel", bus_rr.out_sel, 32'd2);
`endif

        for (int i = 0; i < 400; i++) begin
            in_valid  = 4'($urandom);
            in_data   = 20'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            in_lock   = ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'b0000;
            if (i == 200) pulse_reset();
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
